// File: rtl/seq_mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes)
// producing a 2*WIDTH result as z_high:z_low.
module seq_mul_div_unit #(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] MUL_OP = 5'b01100,
  parameter logic [4:0] DIV_OP = 5'b01101
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic [4:0]       op_code,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  // state | meaning
  // IDLE  | waiting for an accepted Start
  // RUN   | one Booth / restoring iteration per edge
  // FIX   | sign and special-case correction, result registered
  // DONE  | Done pulse, back to IDLE next edge
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qreg;
  logic             q_1;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] a_reg;
  logic             a_neg, b_neg, is_div, b_zero;
  logic             accept;

  assign accept = (state == IDLE) && Start && ((op_code == MUL_OP) || (op_code == DIV_OP));

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        Busy = 1'b1;
        if (count == CW'(1)) state_next = FIX;
      end
      FIX: begin
        Busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Booth step: add/subtract multiplicand, then arithmetic shift of {acc,qreg,q_1}.
  // acc carries one guard bit so -2^(W-1) operands cannot overflow it.
  logic [WIDTH:0]   m_sext, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_q;
  always_comb begin
    m_sext = {m[WIDTH-1], m};
    case ({qreg[0], q_1})
      2'b01:   booth_sum = acc + m_sext;
      2'b10:   booth_sum = acc - m_sext;
      default: booth_sum = acc;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], qreg[WIDTH-1:1]};
  end

  // Restoring step on magnitudes; qreg shifts dividend bits out and quotient bits in.
  logic [WIDTH:0]   r_shift, div_acc;
  logic [WIDTH-1:0] div_q;
  logic             r_ge;
  always_comb begin
    r_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    r_ge    = (r_shift >= {1'b0, m});
    div_acc = r_ge ? (r_shift - {1'b0, m}) : r_shift;
    div_q   = {qreg[WIDTH-2:0], r_ge};
  end

  logic [WIDTH-1:0] fix_high, fix_low;
  always_comb begin
    fix_high = acc[WIDTH-1:0];
    fix_low  = qreg;
    if (is_div) begin
      if (b_zero) begin
        fix_high = a_reg;
        fix_low  = '1;
      end else begin
        fix_high = a_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_low  = (a_neg ^ b_neg) ? -qreg : qreg;
      end
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      count     <= '0;
      acc       <= '0;
      qreg      <= '0;
      q_1       <= 1'b0;
      m         <= '0;
      a_reg     <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      is_div    <= 1'b0;
      b_zero    <= 1'b0;
      z_high    <= '0;
      z_low     <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          count     <= CW'(WIDTH);
          acc       <= '0;
          q_1       <= 1'b0;
          a_reg     <= a_in;
          a_neg     <= a_in[WIDTH-1];
          b_neg     <= b_in[WIDTH-1];
          b_zero    <= (b_in == '0);
          is_div    <= (op_code == DIV_OP);
          DivByZero <= 1'b0;
          if (op_code == DIV_OP) begin
            qreg <= a_in[WIDTH-1] ? -a_in : a_in;
            m    <= b_in[WIDTH-1] ? -b_in : b_in;
          end else begin
            qreg <= a_in;
            m    <= b_in;
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (is_div) begin
            acc  <= div_acc;
            qreg <= div_q;
          end else begin
            acc  <= booth_acc;
            qreg <= booth_q;
            q_1  <= qreg[0];
          end
        end
        FIX: begin
          z_high    <= fix_high;
          z_low     <= fix_low;
          DivByZero <= is_div & b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div_unit.sv
// Directed bench for seq_mul_div_unit: latency, results, ignored starts, async clear.
module tb_seq_mul_div_unit;
  localparam logic [4:0] MUL = 5'b01100;
  localparam logic [4:0] DIV = 5'b01101;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        Start = 1'b0;
  logic [4:0]  op_code = '0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [31:0] z_high, z_low;
  logic        Busy, Done, DivByZero;

  int tests = 0;
  int failed = 0;

  seq_mul_div_unit dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .op_code(op_code),
    .a_in(a_in), .b_in(b_in), .z_high(z_high), .z_low(z_low),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clock);
    op_code = op; a_in = a; b_in = b; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    check({tag, " busy_rise"}, 64'(Busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int elapsed, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dbz);
    int n;
    n = elapsed;
    while (n < 45) begin
      @(posedge Clock); #1;
      n++;
      if (Done) break;
    end
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " z"}, {z_high, z_low}, {exp_hi, exp_lo});
    check({tag, " dbz"}, 64'(DivByZero), 64'(exp_dbz));
    @(posedge Clock); #1;
    check({tag, " done_fall"}, {62'd0, Done, Busy}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
    start_op(tag, op, a, b);
    wait_done(tag, 0, exp_hi, exp_lo, exp_dbz);
  endtask

  initial begin
    #12;
    check("reset_outs", {z_high, z_low}, 64'd0);
    check("reset_flags", {61'd0, Busy, Done, DivByZero}, 64'd0);
    @(negedge Clock); Clear = 1'b1;

    run_op("mul_25x6", MUL, 32'd25, 32'd6, 32'h0000_0000, 32'h0000_0096, 1'b0);
    run_op("mul_m8x6", MUL, 32'hFFFF_FFF8, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD0, 1'b0);
    run_op("mul_min_sq", MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op("mul_zero", MUL, 32'd0, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
    run_op("div_25_6", DIV, 32'd25, 32'd6, 32'd1, 32'd4, 1'b0);
    run_op("div_m25_6", DIV, 32'hFFFF_FFE7, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0);
    run_op("div_25_m6", DIV, 32'd25, 32'hFFFF_FFFA, 32'd1, 32'hFFFF_FFFC, 1'b0);
    run_op("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div_by0", DIV, 32'd25, 32'd0, 32'h0000_0019, 32'hFFFF_FFFF, 1'b1);
    run_op("mul_2x3", MUL, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);

    // Start during RUN with new operands must not disturb the operation.
    start_op("mul_glitch", MUL, 32'd11, 32'd13);
    repeat (9) @(posedge Clock);
    @(negedge Clock);
    op_code = DIV; a_in = 32'd99; b_in = 32'd3; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    wait_done("mul_glitch", 10, 32'h0, 32'd143, 1'b0);

    // Unsupported op_code in IDLE is ignored.
    @(negedge Clock);
    op_code = 5'b00011; a_in = 32'd5; b_in = 32'd5; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    check("badop_busy", 64'(Busy), 64'd0);
    repeat (3) @(posedge Clock); #1;
    check("badop_outs", {z_high, z_low}, {32'h0, 32'd143});
    check("badop_flags", {62'd0, Busy, Done}, 64'd0);

    // Asynchronous clear mid-DIV.
    start_op("div_clr", DIV, 32'd1000, 32'd3);
    repeat (14) @(posedge Clock);
    #2 Clear = 1'b0;
    #1;
    check("clr_outs", {z_high, z_low}, 64'd0);
    check("clr_flags", {61'd0, Busy, Done, DivByZero}, 64'd0);
    @(negedge Clock); Clear = 1'b1;
    run_op("div_100_7", DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
